// File: rtl/booth_r4_multiplier_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM states,
// Booth select codes and the iteration count for a given operand width.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    M2M  = 3'd3,
    MM   = 3'd4
  } booth_sel_t;

  // Two multiplier bits retire per iteration over the (WIDTH+2)-bit extended Q.
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth recoder: decodes {Qx[1], Qx[0], q_m1} and selects the adder
// operand (0, +M, +2M, -2M, -M); negation is ~x with carry-in 1.
module booth_r4_sel
  import mult_pkg::*;
#(
  parameter int E = 10
) (
  input  logic [2:0]   bits,
  input  logic [E-1:0] m,
  output logic [E-1:0] operand,
  output logic         cin
);

  booth_sel_t sel;

  always_comb begin
    case (bits)
      3'b001, 3'b010: sel = PM;
      3'b011:         sel = P2M;
      3'b100:         sel = M2M;
      3'b101, 3'b110: sel = MM;
      default:        sel = ZERO;
    endcase
  end

  always_comb begin
    operand = '0;
    cin     = 1'b0;
    case (sel)
      PM:  operand = m;
      P2M: operand = {m[E-2:0], 1'b0};
      M2M: begin
        operand = ~{m[E-2:0], 1'b0};
        cin     = 1'b1;
      end
      MM: begin
        operand = ~m;
        cin     = 1'b1;
      end
      default: operand = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier with signed/unsigned mode, operand
// latching, synchronous clear and back-to-back restart from DONE.
module booth_r4_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 op_busy,
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int E     = WIDTH + 2;
  localparam int N     = iter_count(WIDTH);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state, state_next;
  logic             load;
  logic [E-1:0]     m_ext;
  logic [E-1:0]     a;
  logic [E-1:0]     qx;
  logic             q_m1;
  logic [CNT_W-1:0] cnt;
  logic [E-1:0]     operand;
  logic             cin;
  logic [E-1:0]     sum;
  logic [E-1:0]     a_next;
  logic [E-1:0]     qx_next;

  function automatic logic [E-1:0] extend(input logic [WIDTH-1:0] x, input logic sm);
    return {{2{sm & x[WIDTH-1]}}, x};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Start is only honoured in IDLE/DONE; clear overrides everything.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    if (op_clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (op_start) begin
            state_next = RUN;
            load       = 1'b1;
          end
        end
        RUN:     if (cnt == LAST) state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  booth_r4_sel #(.E(E)) u_sel (
    .bits    ({qx[1:0], q_m1}),
    .m       (m_ext),
    .operand (operand),
    .cin     (cin)
  );

  // Single E-bit adder, then arithmetic shift of {A, Qx, q_m1} right by 2.
  assign sum     = a + operand + {{(E-1){1'b0}}, cin};
  assign a_next  = {{2{sum[E-1]}}, sum[E-1:2]};
  assign qx_next = {sum[1:0], qx[E-1:2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ext  <= '0;
      a      <= '0;
      qx     <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (op_clear) begin
      m_ext  <= '0;
      a      <= '0;
      qx     <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (load) begin
      m_ext <= extend(multiplicand, signed_mode);
      a     <= '0;
      qx    <= extend(multiplier, signed_mode);
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a    <= a_next;
      qx   <= qx_next;
      q_m1 <= qx[1];
      cnt  <= cnt + 1'b1;
      if (cnt == LAST) result <= {a_next[WIDTH-3:0], qx_next};
    end
  end

  assign op_busy = (state == RUN);
  assign op_done = (state == DONE);

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench for booth_r4_multiplier at WIDTH=8 and WIDTH=64 with a
// scoreboard queue of expected products per instance.
module tb_booth_r4_multiplier;

  logic clk;
  logic reset_n;

  logic        start8, clear8, sm8;
  logic [7:0]  m8, q8;
  logic        busy8, done8;
  logic [15:0] res8;

  logic         start64, clear64, sm64;
  logic [63:0]  m64, q64;
  logic         busy64, done64;
  logic [127:0] res64;

  logic [15:0]  exp8_q[$];
  logic [127:0] exp64_q[$];

  int checks;
  int errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  booth_r4_multiplier #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (start8),
    .op_clear     (clear8),
    .signed_mode  (sm8),
    .multiplicand (m8),
    .multiplier   (q8),
    .op_busy      (busy8),
    .op_done      (done8),
    .result       (res8)
  );

  booth_r4_multiplier #(.WIDTH(64)) dut64 (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (start64),
    .op_clear     (clear64),
    .signed_mode  (sm64),
    .multiplicand (m64),
    .multiplier   (q64),
    .op_busy      (busy64),
    .op_done      (done64),
    .result       (res64)
  );

  // ---------------- golden models ----------------
  function automatic logic [15:0] model8(input logic [7:0] m, input logic [7:0] q, input logic sm);
    logic [15:0] mx, qx;
    mx = sm ? {{8{m[7]}}, m} : {8'h00, m};
    qx = sm ? {{8{q[7]}}, q} : {8'h00, q};
    return mx * qx;
  endfunction

  function automatic logic [127:0] model64(input logic [63:0] m, input logic [63:0] q, input logic sm);
    logic [127:0] mx, qx;
    mx = sm ? {{64{m[63]}}, m} : {64'h0, m};
    qx = sm ? {{64{q[63]}}, q} : {64'h0, q};
    return mx * qx;
  endfunction

  // ---------------- driver tasks ----------------
  // Starts one 8-bit op, waits for op_done and checks latency, busy time and result.
  task automatic run_op8(input logic [7:0] m, input logic [7:0] q, input logic sm,
                         input string name, input bit toggle);
    int edges;
    int busy_cycles;
    logic [15:0] exp;
    exp8_q.push_back(model8(m, q, sm));
    @(negedge clk);
    m8 = m; q8 = q; sm8 = sm; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    edges = 1;
    busy_cycles = 0;
    while (!done8 && edges < 40) begin
      if (busy8) busy_cycles++;
      if (toggle) begin
        q8  = 8'($urandom_range(0, 255));
        m8  = 8'($urandom_range(0, 255));
        sm8 = 1'($urandom_range(0, 1));
        start8 = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      edges++;
    end
    start8 = 1'b0;
    checks++;
    if (edges !== 6) begin
      errors++;
      $display("FAIL %s latency8: got %0d edges, expected 6", name, edges);
    end
    checks++;
    if (busy_cycles !== 5) begin
      errors++;
      $display("FAIL %s busy8: got %0d cycles, expected 5", name, busy_cycles);
    end
    exp = exp8_q.pop_front();
    checks++;
    if (res8 !== exp) begin
      errors++;
      $display("FAIL %s result8: got %h, expected %h", name, res8, exp);
    end
  endtask

  task automatic run_op64(input logic [63:0] m, input logic [63:0] q, input logic sm,
                          input string name);
    int edges;
    logic [127:0] exp;
    exp64_q.push_back(model64(m, q, sm));
    @(negedge clk);
    m64 = m; q64 = q; sm64 = sm; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    edges = 1;
    while (!done64 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges !== 34) begin
      errors++;
      $display("FAIL %s latency64: got %0d edges, expected 34", name, edges);
    end
    exp = exp64_q.pop_front();
    checks++;
    if (res64 !== exp) begin
      errors++;
      $display("FAIL %s result64: got %h, expected %h", name, res64, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    start8 = 0; clear8 = 0; sm8 = 0; m8 = '0; q8 = '0;
    start64 = 0; clear64 = 0; sm64 = 0; m64 = '0; q64 = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy8, done8, res8} !== 18'h0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b result=%h, expected all 0", busy8, done8, res8);
    end
    checks++;
    if ({busy64, done64, res64} !== 130'h0) begin
      errors++;
      $display("FAIL reset64: got busy=%b done=%b result=%h, expected all 0", busy64, done64, res64);
    end
  endtask

  task automatic test_directed8();
    run_op8(8'hF9, 8'h06, 1'b1, "neg7x6", 1'b0);
    checks++;
    if (res8 !== 16'hFFD6) begin
      errors++;
      $display("FAIL neg7x6_const: got %h, expected ffd6", res8);
    end
    run_op8(8'hFF, 8'hFF, 1'b0, "u255x255", 1'b0);
    checks++;
    if (res8 !== 16'hFE01) begin
      errors++;
      $display("FAIL u255x255_const: got %h, expected fe01", res8);
    end
    run_op8(8'hFF, 8'hFF, 1'b1, "s_m1xm1", 1'b0);
    run_op8(8'h80, 8'h80, 1'b1, "s_m128xm128", 1'b0);
    run_op8(8'h80, 8'h7F, 1'b1, "s_m128x127", 1'b0);
    checks++;
    if (res8 !== 16'hC080) begin
      errors++;
      $display("FAIL m128x127_const: got %h, expected c080", res8);
    end
  endtask

  task automatic test_clear_run();
    int done_seen;
    @(negedge clk);
    m8 = 8'd11; q8 = 8'd13; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    clear8 = 1'b1;
    @(negedge clk);
    clear8 = 1'b0;
    checks++;
    if ({busy8, done8, res8} !== 18'h0) begin
      errors++;
      $display("FAIL clear_run: got busy=%b done=%b result=%h, expected all 0", busy8, done8, res8);
    end
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8 || busy8) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL clear_no_done: got %0d active cycles, expected 0", done_seen);
    end
  endtask

  task automatic test_clear_beats_start();
    run_op8(8'd7, 8'd9, 1'b0, "pre_clear", 1'b0);
    @(negedge clk);
    clear8 = 1'b1; start8 = 1'b1; m8 = 8'd2; q8 = 8'd2;
    @(negedge clk);
    clear8 = 1'b0; start8 = 1'b0;
    checks++;
    if ({busy8, done8, res8} !== 18'h0) begin
      errors++;
      $display("FAIL clear_wins: got busy=%b done=%b result=%h, expected all 0", busy8, done8, res8);
    end
  endtask

  task automatic test_reset_run();
    @(negedge clk);
    m8 = 8'd100; q8 = 8'd3; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, res8} !== 18'h0) begin
      errors++;
      $display("FAIL reset_run: got busy=%b done=%b result=%h, expected all 0", busy8, done8, res8);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int low_cycles;
    logic [15:0] exp;
    run_op8(8'd9, 8'd9, 1'b0, "b2b_first", 1'b0);
    exp8_q.push_back(model8(8'd3, 8'd5, 1'b0));
    @(negedge clk);
    m8 = 8'd3; q8 = 8'd5; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    low_cycles = 0;
    while (!done8 && low_cycles < 40) begin
      low_cycles++;
      @(negedge clk);
    end
    checks++;
    if (low_cycles !== 5) begin
      errors++;
      $display("FAIL b2b_gap: got %0d low cycles, expected 5", low_cycles);
    end
    exp = exp8_q.pop_front();
    checks++;
    if (res8 !== exp || res8 !== 16'h000F) begin
      errors++;
      $display("FAIL b2b_result: got %h, expected %h", res8, exp);
    end
  endtask

  task automatic test_isolation();
    run_op8(8'hE3, 8'h5A, 1'b1, "iso_signed", 1'b1);
    run_op8(8'hC8, 8'h9B, 1'b0, "iso_unsigned", 1'b1);
  endtask

  task automatic test_random8();
    for (int i = 0; i < 40; i++) begin
      run_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), "rand8", 1'b0);
    end
  endtask

  task automatic test_w64();
    logic [63:0] corners[5];
    corners[0] = 64'h0;
    corners[1] = 64'h1;
    corners[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    corners[3] = 64'h8000_0000_0000_0000;
    corners[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        run_op64(corners[i], corners[j], 1'b1, "corner64_s");
        run_op64(corners[i], corners[j], 1'b0, "corner64_u");
      end
    end
    for (int i = 0; i < 200; i++) begin
      run_op64({$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 1)), "rand64");
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed8();
    test_clear_run();
    test_clear_beats_start();
    test_reset_run();
    test_back_to_back();
    test_isolation();
    test_random8();
    test_w64();
    checks++;
    if (exp8_q.size() != 0 || exp64_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0",
               exp8_q.size(), exp64_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
